// File: rtl/seq_alu_pkg.sv
//------------------------------------------------------------------------------
// Module : seq_alu_pkg
// Brief  : Opcodes, controller states and NZVC flag bit positions for seq_alu.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package seq_alu_pkg;

  localparam logic [3:0] c_OP_ADD = 4'd0;
  localparam logic [3:0] c_OP_SUB = 4'd1;
  localparam logic [3:0] c_OP_AND = 4'd2;
  localparam logic [3:0] c_OP_OR  = 4'd3;
  localparam logic [3:0] c_OP_XOR = 4'd4;
  localparam logic [3:0] c_OP_INC = 4'd5;
  localparam logic [3:0] c_OP_DEC = 4'd6;
  localparam logic [3:0] c_OP_ADC = 4'd7;
  localparam logic [3:0] c_OP_SBC = 4'd8;
  localparam logic [3:0] c_OP_SHL = 4'd9;
  localparam logic [3:0] c_OP_SHR = 4'd10;
  localparam logic [3:0] c_OP_ASR = 4'd11;
  localparam logic [3:0] c_OP_CMP = 4'd12;
  localparam logic [3:0] c_OP_MUL = 4'd13;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  localparam int c_FLAG_N = 3;
  localparam int c_FLAG_Z = 2;
  localparam int c_FLAG_V = 1;
  localparam int c_FLAG_C = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic v, input logic c);
    return {n, z, v, c};
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_mul.sv
//------------------------------------------------------------------------------
// Module : seq_alu_mul
// Brief  : Unsigned shift-add multiplier, one partial product per clock.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_alu_mul #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] multiplicand,
  input  logic [DATA_WIDTH-1:0] multiplier,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product_hi,
  output logic [DATA_WIDTH-1:0] product_lo
);

  localparam int c_CW = $clog2(DATA_WIDTH);

  logic                  r_busy;
  logic [c_CW-1:0]       r_count;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;
  logic [DATA_WIDTH:0]   w_sum;

  // done and product describe the state after the iteration in progress, so
  // the caller can register the final product on the same edge it completes.
  assign w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign done       = r_busy && (r_count == c_CW'(DATA_WIDTH - 1));
  assign product_hi = w_sum[DATA_WIDTH:1];
  assign product_lo = {w_sum[0], r_lo[DATA_WIDTH-1:1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_count <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (start) begin
      r_busy  <= 1'b1;
      r_count <= '0;
      r_mcand <= multiplicand;
      r_hi    <= '0;
      r_lo    <= multiplier;
    end else if (r_busy) begin
      r_hi    <= product_hi;
      r_lo    <= product_lo;
      r_count <= r_count + c_CW'(1);
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
//------------------------------------------------------------------------------
// Module : seq_alu
// Brief  : Registered handshake ALU with sticky NZVC flags; the multi-cycle
//          multiplier is built only when SEQ_ALU_MUL_EN is defined.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic                  flag_clear,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] aluResult,
  output logic [DATA_WIDTH-1:0] aluResultHi,
  output logic [3:0]            NZVCflags
);

  localparam int c_MSB = DATA_WIDTH - 1;

  state_t                r_state;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_result_hi;
  logic [3:0]            r_flags;

  logic                  w_accept;
  logic                  w_start_mul;
  logic [3:0]            w_base;
  logic [DATA_WIDTH-1:0] w_b;
  logic                  w_ci;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_dif;
  logic                  w_add_v;
  logic                  w_sub_v;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_c;
  logic                  w_v;
  logic                  w_upd;
  logic                  w_hold;
  logic [3:0]            w_flags;
  logic                  w_mul_done;
  logic [DATA_WIDTH-1:0] w_mul_hi;
  logic [DATA_WIDTH-1:0] w_mul_lo;
  logic [3:0]            w_mul_flags;

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign aluResult   = r_result;
  assign aluResultHi = r_result_hi;
  assign NZVCflags   = r_flags;
  assign w_accept    = in_valid && in_ready;

  // A same-cycle flag_clear takes effect before ADC/SBC read the stored carry.
  assign w_base  = flag_clear ? 4'b0000 : r_flags;
  assign w_b     = (opcode == c_OP_INC || opcode == c_OP_DEC) ? DATA_WIDTH'(1) : operand2;
  assign w_ci    = (opcode == c_OP_ADC || opcode == c_OP_SBC) && w_base[c_FLAG_C];
  assign w_sum   = {1'b0, operand1} + {1'b0, w_b} + {{DATA_WIDTH{1'b0}}, w_ci};
  assign w_dif   = {1'b0, operand1} - {1'b0, w_b} - {{DATA_WIDTH{1'b0}}, w_ci};
  assign w_add_v = (operand1[c_MSB] == w_b[c_MSB]) && (w_sum[c_MSB] != operand1[c_MSB]);
  assign w_sub_v = (operand1[c_MSB] != w_b[c_MSB]) && (w_dif[c_MSB] != operand1[c_MSB]);

  always_comb begin
    w_res   = '1;
    w_c     = w_base[c_FLAG_C];
    w_v     = 1'b0;
    w_upd   = 1'b1;
    w_hold  = 1'b0;
    case (opcode)
      c_OP_ADD, c_OP_INC, c_OP_ADC: begin
        w_res = w_sum[c_MSB:0];
        w_c   = w_sum[DATA_WIDTH];
        w_v   = w_add_v;
      end
      c_OP_SUB, c_OP_DEC, c_OP_SBC, c_OP_CMP: begin
        w_res  = w_dif[c_MSB:0];
        w_c    = w_dif[DATA_WIDTH];
        w_v    = w_sub_v;
        w_hold = (opcode == c_OP_CMP);
      end
      c_OP_AND: w_res = operand1 & operand2;
      c_OP_OR:  w_res = operand1 | operand2;
      c_OP_XOR: w_res = operand1 ^ operand2;
      c_OP_SHL: begin
        w_res = {operand1[c_MSB-1:0], 1'b0};
        w_c   = operand1[c_MSB];
      end
      c_OP_SHR: begin
        w_res = {1'b0, operand1[c_MSB:1]};
        w_c   = operand1[0];
      end
      c_OP_ASR: begin
        w_res = {operand1[c_MSB], operand1[c_MSB:1]};
        w_c   = operand1[0];
      end
      default: w_upd = 1'b0;
    endcase
    w_flags = w_upd ? pack_flags(w_res[c_MSB], (w_res == '0), w_v, w_c) : w_base;
  end

`ifdef SEQ_ALU_MUL_EN
  assign w_start_mul = (opcode == c_OP_MUL);

  seq_alu_mul #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mul (
    .clock        (clock),
    .reset        (reset),
    .start        (w_accept && w_start_mul),
    .multiplicand (operand1),
    .multiplier   (operand2),
    .done         (w_mul_done),
    .product_hi   (w_mul_hi),
    .product_lo   (w_mul_lo)
  );
`else
  assign w_start_mul = 1'b0;
  assign w_mul_done  = 1'b0;
  assign w_mul_hi    = '0;
  assign w_mul_lo    = '0;
`endif

  assign w_mul_flags = pack_flags(w_mul_hi[c_MSB], ({w_mul_hi, w_mul_lo} == '0),
                                  (w_mul_hi != '0), (w_mul_hi != '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (flag_clear) begin
        r_flags <= '0;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_start_mul) begin
              r_state <= MUL_RUN;
            end else begin
              r_out_valid <= 1'b1;
              r_flags     <= w_flags;
              if (!w_hold) begin
                r_result    <= w_res;
                r_result_hi <= '0;
              end
            end
          end
        end
        MUL_RUN: begin
          if (w_mul_done) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b1;
            r_result    <= w_mul_lo;
            r_result_hi <= w_mul_hi;
            r_flags     <= w_mul_flags;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
//------------------------------------------------------------------------------
// Module : tb_seq_alu
// Brief  : Self-checking bench for seq_alu (directed table, corner sequences,
//          randomized ops against an arithmetic reference model).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_alu;

  localparam int DW = 8;
`ifdef SEQ_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          flag_clear = 1'b0;
  logic [3:0]    opcode = 4'd0;
  logic [DW-1:0] op1 = '0;
  logic [DW-1:0] op2 = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] res;
  logic [DW-1:0] hi;
  logic [3:0]    flags;

  seq_alu #(.DATA_WIDTH(DW)) dut (
    .clock       (clk),
    .reset       (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .operand1    (op1),
    .operand2    (op2),
    .flag_clear  (flag_clear),
    .out_valid   (out_valid),
    .aluResult   (res),
    .aluResultHi (hi),
    .NZVCflags   (flags)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_res = '0;
  logic [7:0] m_hi = '0;
  logic [3:0] m_flags = '0;
  int         m_lat = 1;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    bit         clr;
    logic [7:0] res;
    logic [3:0] flags;
  } vec_t;

  vec_t tbl [0:21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sgn(input int u);
    return (u >= 128) ? u - 256 : u;
  endfunction

  function automatic bit ovf(input int s);
    return (s > 127) || (s < -128);
  endfunction

  // Reference: plain integer arithmetic with signed-overflow range checks.
  task automatic model_apply(input logic [3:0] op, input logic [7:0] a,
                             input logic [7:0] b, input bit clr);
    int ua, ub, c, s, r, p;
    bit nv, nc, hold, illegal, mul;
    logic [3:0] base;
    ua = int'(a); ub = int'(b);
    base = clr ? 4'b0000 : m_flags;
    c = int'(base[0]);
    nv = 1'b0; nc = base[0]; hold = 1'b0; illegal = 1'b0; mul = 1'b0;
    s = 0; r = 0; p = 0;
    m_lat = 1;
    case (op)
      4'd0:  begin s = ua + ub;     nc = (s > 255); nv = ovf(sgn(ua) + sgn(ub)); end
      4'd5:  begin s = ua + 1;      nc = (s > 255); nv = ovf(sgn(ua) + 1); end
      4'd7:  begin s = ua + ub + c; nc = (s > 255); nv = ovf(sgn(ua) + sgn(ub) + c); end
      4'd1, 4'd12: begin
        s = ua - ub; nc = (ua < ub); nv = ovf(sgn(ua) - sgn(ub)); hold = (op == 4'd12);
      end
      4'd6:  begin s = ua - 1;      nc = (ua < 1);  nv = ovf(sgn(ua) - 1); end
      4'd8:  begin s = ua - ub - c; nc = (ua < ub + c); nv = ovf(sgn(ua) - sgn(ub) - c); end
      4'd2:  s = ua & ub;
      4'd3:  s = ua | ub;
      4'd4:  s = ua ^ ub;
      4'd9:  begin s = ua * 2; nc = (ua >= 128); end
      4'd10: begin s = ua / 2; nc = (ua % 2 == 1); end
      4'd11: begin s = ua / 2 + ((ua >= 128) ? 128 : 0); nc = (ua % 2 == 1); end
      4'd13: begin if (MUL_EN) mul = 1'b1; else illegal = 1'b1; end
      default: illegal = 1'b1;
    endcase
    r = (s + 512) % 256;
    if (illegal) begin
      m_res = 8'hFF; m_hi = 8'h00; m_flags = base;
    end else if (mul) begin
      p = ua * ub;
      m_res = 8'(p % 256); m_hi = 8'(p / 256);
      m_flags = {p >= 32768, p == 0, p >= 256, p >= 256};
      m_lat = DW + 1;
    end else begin
      m_flags = {r >= 128, r == 0, nv, nc};
      if (!hold) begin
        m_res = 8'(r); m_hi = 8'h00;
      end
    end
  endtask

  task automatic model_reset();
    m_res = '0; m_hi = '0; m_flags = '0;
  endtask

  // Drive one op, wait (bounded) for out_valid, compare against the model.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit clr, output int lat);
    @(negedge clk);
    in_valid = 1'b1; opcode = op; op1 = a; op2 = b; flag_clear = clr;
    model_apply(op, a, b, clr);
    @(posedge clk); #1;
    in_valid = 1'b0; flag_clear = 1'b0;
    op1 = 8'($urandom); op2 = 8'($urandom); opcode = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk("in_ready_busy", in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, m_lat);
    chk("in_ready_done", in_ready, 1);
    chk("result", res, m_res);
    chk("result_hi", hi, m_hi);
    chk("flags", flags, m_flags);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    bit seen;
    logic [3:0] rop;
    logic [7:0] ra, rb;

    tbl = '{
      '{4'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 4'b1010},
      '{4'd1,  8'h00, 8'h01, 1'b0, 8'hFF, 4'b1001},
      '{4'd7,  8'h10, 8'h20, 1'b0, 8'h31, 4'b0000},
      '{4'd9,  8'h81, 8'h00, 1'b0, 8'h02, 4'b0001},
      '{4'd11, 8'h80, 8'h00, 1'b0, 8'hC0, 4'b1000},
      '{4'd12, 8'h05, 8'h05, 1'b0, 8'hC0, 4'b0100},
      '{4'd2,  8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000},
      '{4'd4,  8'hAA, 8'hAA, 1'b0, 8'h00, 4'b0100},
      '{4'd6,  8'h00, 8'h00, 1'b0, 8'hFF, 4'b1001},
      '{4'd3,  8'h01, 8'h80, 1'b0, 8'h81, 4'b1001},
      '{4'd8,  8'h10, 8'h05, 1'b0, 8'h0A, 4'b0000},
      '{4'd5,  8'h7F, 8'h00, 1'b0, 8'h80, 4'b1010},
      '{4'd10, 8'h01, 8'h00, 1'b0, 8'h00, 4'b0101},
      '{4'd15, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0101},
      '{4'd1,  8'h00, 8'h01, 1'b0, 8'hFF, 4'b1001},
      '{4'd7,  8'h01, 8'h01, 1'b1, 8'h02, 4'b0000},
      '{4'd7,  8'h80, 8'h80, 1'b0, 8'h00, 4'b0111},
      '{4'd7,  8'h01, 8'h01, 1'b0, 8'h03, 4'b0000},
      '{4'd8,  8'h00, 8'h00, 1'b0, 8'h00, 4'b0100},
      '{4'd1,  8'h00, 8'h01, 1'b0, 8'hFF, 4'b1001},
      '{4'd8,  8'h00, 8'hFF, 1'b0, 8'h00, 4'b0101},
      '{4'd14, 8'h12, 8'h34, 1'b0, 8'hFF, 4'b0101}
    };

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", res, 0);
    chk("rst_hi", hi, 0);
    chk("rst_flags", flags, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, issued back-to-back
    for (int i = 0; i < 22; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].clr, lat);
      chk("tbl_result", res, tbl[i].res);
      chk("tbl_flags", flags, tbl[i].flags);
    end
    @(posedge clk); #1;
    chk("out_valid_pulse", out_valid, 0);

    // MUL boundary FF x FF
    run_op(4'd13, 8'hFF, 8'hFF, 1'b0, lat);
`ifdef SEQ_ALU_MUL_EN
    chk("mul_latency", lat, 9);
    chk("mul_lo", res, 8'h01);
    chk("mul_hi", hi, 8'hFE);
    chk("mul_flags", flags, 4'b1011);
`else
    chk("mul_off_latency", lat, 1);
    chk("mul_off_result", res, 8'hFF);
    chk("mul_off_hi", hi, 8'h00);
    chk("mul_off_flags", flags, 4'b0101);
`endif

    // flag_clear with no request
    @(negedge clk); flag_clear = 1'b1;
    @(posedge clk); #1; flag_clear = 1'b0;
    model_reset();
    chk("idle_clear_flags", flags, 0);
    chk("idle_clear_result_kept", res, MUL_EN ? 8'h01 : 8'hFF);
    m_res = res; m_hi = hi;
    if (MUL_EN) begin
      // flag_clear while the multiplier runs
      run_op(4'd1, 8'h00, 8'h01, 1'b0, lat);
      @(negedge clk);
      in_valid = 1'b1; opcode = 4'd13; op1 = 8'h02; op2 = 8'h03;
      model_apply(4'd13, 8'h02, 8'h03, 1'b0);
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk); flag_clear = 1'b1;
      @(posedge clk); #1; flag_clear = 1'b0;
      chk("mulrun_clear_flags", flags, 0);
      chk("mulrun_no_valid", out_valid, 0);
      lat = 2;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("mulclr_latency", lat, 9);
      chk("mulclr_lo", res, 8'h06);
      chk("mulclr_hi", hi, 8'h00);
      chk("mulclr_flags", flags, 4'b0000);
    end

    // Reset in the middle of a multiply
    run_op(4'd0, 8'h11, 8'h22, 1'b0, lat);
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'd13; op1 = 8'hFF; op2 = 8'hFF;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    chk("abort_result", res, 0);
    chk("abort_hi", hi, 0);
    chk("abort_flags", flags, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    model_reset();
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);

    // Randomized operations against the reference model
    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: ra = 8'h00;
        1: ra = ($urandom_range(0, 1) == 1) ? 8'h7F : 8'h80;
        default: ra = 8'($urandom);
      endcase
      rb = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
      run_op(rop, ra, rb, ($urandom_range(0, 7) == 0), lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
